// File: rtl/pc_control.sv
// Fetch-side PC stage: program counter, N/Z/V flag register, B/BR/HLT decode and branch resolution.
// Optional PC_STALL_EN adds a stall input that freezes the PC and defers HLT detection.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst,
  input  logic [2:0]  flags_wr,
  input  logic [2:0]  flags_in,
  input  logic [15:0] rs_data,
`ifdef PC_STALL_EN
  input  logic        stall,
`endif
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        hlt
);

  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        hlt_q, hlt_d;

  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic        is_b, is_br, is_hlt;
  logic        flag_z, flag_v, flag_n;
  logic        cond_met;
  logic        stall_w;
  logic [15:0] b_target, target;

`ifdef PC_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign opcode = inst[15:12];
  assign ccc    = inst[11:9];
  assign is_b   = (opcode == 4'hC);
  assign is_br  = (opcode == 4'hD);
  assign is_hlt = (opcode == 4'hF);

  // Flag register layout is {Z,V,N}; conditions see only the registered copy.
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_n = flags_q[0];

  always_comb begin
    cond_met = 1'b0;
    case (ccc)
      3'b000:  cond_met = !flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = !flag_z && !flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_met = flag_n || flag_z;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  assign pc_plus      = pc_q + PC_INC;
  assign b_target     = pc_plus + {{6{inst[8]}}, inst[8:0], 1'b0};
  assign target       = is_br ? rs_data : b_target;
  assign branch_taken = (is_b || is_br) && cond_met && !hlt_q;

  always_comb begin
    pc_d    = pc_q;
    flags_d = flags_q;
    hlt_d   = hlt_q;
    if (!hlt_q) begin
      flags_d = (flags_q & ~flags_wr) | (flags_in & flags_wr);
      // A stalled cycle neither advances nor halts; flag writes still land.
      if (!stall_w) begin
        if (is_hlt) begin
          hlt_d = 1'b1;
        end else begin
          pc_d = branch_taken ? target : pc_plus;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
      hlt_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      hlt_q   <= hlt_d;
    end
  end

  assign pc    = pc_q;
  assign flags = flags_q;
  assign hlt   = hlt_q;

endmodule
